// File: rtl/mem_pkg.sv
// Shared constants and FSM state type for the MEM-stage data-memory access controller.
package mem_pkg;

  localparam logic [1:0] MEM_B            = 2'b00;
  localparam logic [1:0] MEM_H            = 2'b01;
  localparam logic [1:0] MEM_W            = 2'b10;
  localparam int         MEM_UNSIGNED_BIT = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DONE = 2'b10
  } mem_state_t;

endpackage

// File: rtl/load_extend.sv
// Lane select and sign/zero extension of a loaded word; pure combinational, reusable by a cache.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_fmt,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_uns;

  assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_word[{i_addr_lo[1], 4'b0000} +: 16];
  assign w_uns  = i_fmt[MEM_UNSIGNED_BIT];

  always_comb begin
    o_result = i_word;
    case (i_fmt[1:0])
      MEM_B:   o_result = w_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      MEM_H:   o_result = w_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: o_result = i_word;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: req/ack handshake, stall request, write mask and load extension.
// Optional WAIT timeout abort is built when MEM_TIMEOUT_EN is defined.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_r_MEM,
  input  logic        mem_w_MEM,
  input  logic [2:0]  u_b_h_w_MEM,
  input  logic [31:0] addr_MEM,
  input  logic [31:0] wdata_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wmask,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_req_MEM,
  output logic [31:0] rdata_MEM,
  output logic        misalign_MEM,
  output logic        timeout_MEM
);

  mem_state_t  r_state, w_state_nxt;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_wmask;
  logic [2:0]  r_fmt;
  logic        r_we, r_is_load;

  logic        w_access, w_aligned, w_go, w_idle, w_req, w_to_hit, w_timeout_fire;
  logic [3:0]  w_wmask_c;
  logic [31:0] w_wdata_c, w_ext;

  assign w_access = mem_r_MEM | mem_w_MEM;
  assign w_idle   = (r_state == S_IDLE);

  always_comb begin
    case (u_b_h_w_MEM[1:0])
      MEM_B:   w_aligned = 1'b1;
      MEM_H:   w_aligned = ~addr_MEM[0];
      default: w_aligned = (addr_MEM[1:0] == 2'b00);
    endcase
  end

  // rstn gates the request so an outstanding transaction drops the instant reset asserts
  assign w_go = w_access & w_aligned & rstn;

  always_comb begin
    w_wmask_c = 4'b0000;
    w_wdata_c = wdata_MEM;
    case (u_b_h_w_MEM[1:0])
      MEM_B: begin
        w_wmask_c = 4'b0001 << addr_MEM[1:0];
        w_wdata_c = {4{wdata_MEM[7:0]}};
      end
      MEM_H: begin
        w_wmask_c = 4'b0011 << {addr_MEM[1], 1'b0};
        w_wdata_c = {2{wdata_MEM[15:0]}};
      end
      default: w_wmask_c = 4'b1111;
    endcase
    if (!mem_w_MEM) w_wmask_c = 4'b0000;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_timeout_fire = 1'b0;
    case (r_state)
      S_IDLE: if (w_go) w_state_nxt = dmem_ack ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (dmem_ack) begin
          w_state_nxt = S_DONE;
        end else if (w_to_hit) begin
          w_state_nxt    = S_DONE;
          w_timeout_fire = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_req = (w_idle & w_go) | (r_state == S_WAIT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wmask   <= '0;
      r_fmt     <= '0;
      r_we      <= 1'b0;
      r_is_load <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_idle && w_go) begin
        r_addr    <= addr_MEM;
        r_wdata   <= w_wdata_c;
        r_wmask   <= w_wmask_c;
        r_fmt     <= u_b_h_w_MEM;
        r_we      <= mem_w_MEM;
        r_is_load <= mem_r_MEM;
      end
      if (w_req && dmem_ack) r_rdata <= dmem_rdata;
      else if (w_timeout_fire) r_rdata <= '0;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] r_wait_cnt;
  logic          r_timeout;

  // down-counter loaded on entry to WAIT; terminal count 1 marks the last allowed WAIT cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_timeout_fire;
      if (w_idle && w_state_nxt == S_WAIT) r_wait_cnt <= CW'(TIMEOUT_CYC);
      else if (r_state == S_WAIT)
        r_wait_cnt <= (w_state_nxt != S_WAIT) ? '0 : r_wait_cnt - CW'(1);
    end
  end

  assign w_to_hit    = (r_wait_cnt == CW'(1));
  assign timeout_MEM = r_timeout;
`else
  assign w_to_hit    = 1'b0;
  assign timeout_MEM = 1'b0;
`endif

  load_extend u_load_extend (
    .i_word    (r_rdata),
    .i_addr_lo (r_addr[1:0]),
    .i_fmt     (r_fmt),
    .o_result  (w_ext)
  );

  assign dmem_req      = w_req;
  assign dmem_we       = w_idle ? (w_go & mem_w_MEM) : r_we;
  assign dmem_addr     = w_idle ? {addr_MEM[31:2], 2'b00} : {r_addr[31:2], 2'b00};
  assign dmem_wdata    = w_idle ? w_wdata_c : r_wdata;
  assign dmem_wmask    = w_idle ? (w_go ? w_wmask_c : 4'b0000) : r_wmask;
  assign stall_req_MEM = w_go & (r_state != S_DONE);
  assign misalign_MEM  = w_access & ~w_aligned;
  assign rdata_MEM     = (r_state == S_DONE && r_is_load) ? w_ext : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl; timeout scenario is exercised when MEM_TIMEOUT_EN is defined.
module tb_mem_access_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam int TB_TO = 4;
`else
  localparam int TB_TO = 64;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_r_MEM, mem_w_MEM;
  logic [2:0]  u_b_h_w_MEM;
  logic [31:0] addr_MEM, wdata_MEM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall_req_MEM;
  logic [31:0] rdata_MEM;
  logic        misalign_MEM, timeout_MEM;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT_CYC(TB_TO)) dut (
    .clk(clk), .rstn(rstn),
    .mem_r_MEM(mem_r_MEM), .mem_w_MEM(mem_w_MEM), .u_b_h_w_MEM(u_b_h_w_MEM),
    .addr_MEM(addr_MEM), .wdata_MEM(wdata_MEM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_req_MEM(stall_req_MEM), .rdata_MEM(rdata_MEM),
    .misalign_MEM(misalign_MEM), .timeout_MEM(timeout_MEM)
  );

  typedef struct {
    int          stall;
    int          req;
    bit          misalign;
    bit          first_req;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    bit          unstable;
    bit          done_req;
    logic [31:0] rdata;
    bit          tmo;
    bit          bound_hit;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f);
    return (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit m_aligned(input logic [2:0] f, input logic [31:0] a);
    return (a % m_size(f)) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f);
    longint v, span;
    int     sz;
    sz   = m_size(f);
    span = longint'(1) << (8 * sz);
    v    = (longint'(w) >> (8 * (a % 4))) % span;
    if (!f[2] && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  function automatic logic [3:0] m_wmask(input logic [2:0] f, input logic [31:0] a);
    int sz;
    sz = m_size(f);
    if (sz == 1) return 4'(1 << (a % 4));
    if (sz == 2) return 4'(3 << (a % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] d);
    int sz;
    sz = m_size(f);
    if (sz == 1) return (d % 256) * 32'h0101_0101;
    if (sz == 2) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  // ---------------- stimulus driver (observes, does not judge) ----------------
  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      mem_r_MEM = 1'b0; mem_w_MEM = 1'b0; dmem_ack = 1'b0;
    end
  endtask

  // ack_at: ack is high during the ack_at-th request cycle; 0 means never
  task automatic run_access(input bit is_store, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] wd, input int ack_at, input logic [31:0] rword,
                            output obs_t o);
    int cyc;
    @(posedge clk); #1;
    mem_r_MEM = !is_store; mem_w_MEM = is_store; u_b_h_w_MEM = f;
    addr_MEM = a; wdata_MEM = wd; dmem_rdata = rword; dmem_ack = (ack_at == 1);
    o = '{default: '0};
    cyc = 0;
    @(negedge clk);
    o.misalign  = misalign_MEM;
    o.first_req = dmem_req;
    o.we = dmem_we; o.addr = dmem_addr; o.wdata = dmem_wdata; o.wmask = dmem_wmask;
    while (stall_req_MEM && cyc < 200) begin
      cyc++;
      o.stall++;
      if (dmem_req) o.req++;
      if (dmem_we !== o.we || dmem_addr !== o.addr || dmem_wdata !== o.wdata || dmem_wmask !== o.wmask)
        o.unstable = 1'b1;
      @(posedge clk); #1;
      dmem_ack = (cyc + 1 == ack_at);
      @(negedge clk);
    end
    o.bound_hit = (cyc >= 200);
    o.done_req  = dmem_req;
    o.rdata     = rdata_MEM;
    o.tmo       = timeout_MEM;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rstn = 1'b0;
    mem_r_MEM = 0; mem_w_MEM = 0; u_b_h_w_MEM = 0; addr_MEM = 0; wdata_MEM = 0;
    dmem_ack = 0; dmem_rdata = 0;
    #12;
    n_tests++;
    if ({dmem_req, stall_req_MEM, timeout_MEM, misalign_MEM} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {dmem_req, stall_req_MEM, timeout_MEM, misalign_MEM});
    end
    n_tests++;
    if (rdata_MEM !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata_MEM); end
    @(negedge clk); rstn = 1'b1;
  endtask

  task automatic test_loads;
    obs_t o;
    run_access(0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF, o);
    n_tests++;
    if (o.stall !== 3) begin n_fail++; $display("FAIL lw_stall: got %0d want 3", o.stall); end
    n_tests++;
    if (o.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata: got %h want deadbeef", o.rdata); end
    n_tests++;
    if (o.wmask !== 4'h0 || o.we !== 1'b0 || o.addr !== 32'h100) begin
      n_fail++; $display("FAIL lw_req: wmask %h we %b addr %h want 0 0 100", o.wmask, o.we, o.addr);
    end
    run_access(0, 3'b000, 32'h103, 32'h0, 2, 32'h80FF_0000, o);
    n_tests++;
    if (o.rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata: got %h want ffffff80", o.rdata); end
    run_access(0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF_0000, o);
    n_tests++;
    if (o.rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_rdata: got %h want 00000080", o.rdata); end
    n_tests++;
    if (o.stall !== 1) begin n_fail++; $display("FAIL lbu_stall: got %0d want 1", o.stall); end
    drive_idle(1);
  endtask

  task automatic test_store_same_cycle;
    obs_t o;
    run_access(1, 3'b001, 32'h202, 32'h1234ABCD, 1, 32'h0, o);
    n_tests++;
    if (o.wmask !== 4'b1100) begin n_fail++; $display("FAIL sh_wmask: got %b want 1100", o.wmask); end
    n_tests++;
    if (o.wdata !== 32'hABCDABCD) begin n_fail++; $display("FAIL sh_wdata: got %h want abcdabcd", o.wdata); end
    n_tests++;
    if (o.stall !== 1 || o.we !== 1'b1 || o.addr !== 32'h200) begin
      n_fail++; $display("FAIL sh_req: stall %0d we %b addr %h want 1 1 200", o.stall, o.we, o.addr);
    end
    drive_idle(1);
  endtask

  task automatic test_misaligned;
    obs_t o;
    run_access(0, 3'b010, 32'h101, 32'h0, 1, 32'hFFFF_FFFF, o);
    n_tests++;
    if ({o.misalign, o.first_req, o.stall != 0} !== 3'b100) begin
      n_fail++; $display("FAIL misalign_lw: misalign %b req %b stall %0d want 1 0 0", o.misalign, o.first_req, o.stall);
    end
    n_tests++;
    if (o.rdata !== 32'h0) begin n_fail++; $display("FAIL misalign_rdata: got %h want 0", o.rdata); end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if (dmem_req !== 1'b0 || stall_req_MEM !== 1'b0) begin
      n_fail++; $display("FAIL misalign_hold: req %b stall %b want 0 0", dmem_req, stall_req_MEM);
    end
    drive_idle(1);
  endtask

  task automatic test_spurious_ack;
    obs_t o;
    @(posedge clk); #1;
    mem_r_MEM = 0; mem_w_MEM = 0; dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if (dmem_req !== 1'b0 || rdata_MEM !== 32'h0) begin
      n_fail++; $display("FAIL spurious_ack: req %b rdata %h want 0 0", dmem_req, rdata_MEM);
    end
    run_access(0, 3'b001, 32'h0000_0A02, 32'h0, 2, 32'h8001_7FFF, o);
    n_tests++;
    if (o.stall !== 2 || o.rdata !== 32'hFFFF_8001) begin
      n_fail++; $display("FAIL after_spurious: stall %0d rdata %h want 2 ffff8001", o.stall, o.rdata);
    end
    drive_idle(1);
  endtask

  task automatic test_reset_mid;
    obs_t o;
    @(posedge clk); #1;
    mem_r_MEM = 1; mem_w_MEM = 0; u_b_h_w_MEM = 3'b010; addr_MEM = 32'h300; dmem_ack = 0;
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (dmem_req !== 1'b1 || stall_req_MEM !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: req %b stall %b want 1 1", dmem_req, stall_req_MEM);
    end
    #2 rstn = 1'b0;
    #1;
    n_tests++;
    if (dmem_req !== 1'b0 || stall_req_MEM !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_drop: req %b stall %b want 0 0", dmem_req, stall_req_MEM);
    end
    mem_r_MEM = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    run_access(1, 3'b010, 32'h304, 32'hCAFE_F00D, 2, 32'h0, o);
    n_tests++;
    if (o.stall !== 2 || o.wmask !== 4'hF || o.wdata !== 32'hCAFEF00D || o.done_req !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_sw: stall %0d wmask %h wdata %h done_req %b want 2 f cafef00d 0",
                         o.stall, o.wmask, o.wdata, o.done_req);
    end
    drive_idle(1);
  endtask

  task automatic test_long_wait;
    obs_t o;
`ifdef MEM_TIMEOUT_EN
    run_access(0, 3'b010, 32'h400, 32'h0, 0, 32'h1111_2222, o);
    n_tests++;
    if (o.stall !== TB_TO + 1 || o.tmo !== 1'b1 || o.rdata !== 32'h0 || o.bound_hit) begin
      n_fail++; $display("FAIL timeout: stall %0d tmo %b rdata %h want %0d 1 0", o.stall, o.tmo, o.rdata, TB_TO + 1);
    end
    @(posedge clk); #1;
    mem_r_MEM = 0;
    @(negedge clk);
    n_tests++;
    if (timeout_MEM !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse: got %b want 0", timeout_MEM); end
`else
    run_access(0, 3'b010, 32'h400, 32'h0, 12, 32'h1111_2222, o);
    n_tests++;
    if (o.stall !== 12 || o.tmo !== 1'b0 || o.rdata !== 32'h1111_2222) begin
      n_fail++; $display("FAIL long_wait: stall %0d tmo %b rdata %h want 12 0 11112222", o.stall, o.tmo, o.rdata);
    end
`endif
    drive_idle(1);
  endtask

  // random back-to-back traffic; idle gaps inserted only occasionally
  task automatic test_random;
    obs_t o;
    logic [31:0] a, wd, rw;
    logic [2:0]  f;
    bit          st, al;
    int          lat;
    logic [31:0] exp_rd;
    for (int i = 0; i < 80; i++) begin
      a   = $urandom;
      wd  = $urandom;
      rw  = $urandom;
      f   = 3'($urandom_range(0, 7));
      st  = ($urandom_range(0, 1) == 1);
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 3) != 0) a = a - (a % m_size(f)) + (($urandom_range(0, 5) == 0) ? 1 : 0);
      al = m_aligned(f, a);
      exp_rd = (!al || st) ? 32'h0 : m_load(rw, a, f);
      run_access(st, f, a, wd, lat, rw, o);
      n_tests++;
      if (o.misalign !== !al || o.stall !== (al ? lat : 0) || o.req !== o.stall || o.bound_hit) begin
        n_fail++; $display("FAIL rnd_ctrl[%0d]: mis %b stall %0d req %0d want mis %b stall %0d",
                           i, o.misalign, o.stall, o.req, !al, al ? lat : 0);
      end
      n_tests++;
      if (o.rdata !== exp_rd || o.done_req !== 1'b0) begin
        n_fail++; $display("FAIL rnd_rdata[%0d]: got %h req %b want %h 0 (f=%b a=%h w=%h)",
                           i, o.rdata, o.done_req, exp_rd, f, a, rw);
      end
      if (al) begin
        n_tests++;
        if (o.unstable || o.addr !== a - (a % 4) || o.we !== st ||
            o.wmask !== (st ? m_wmask(f, a) : 4'h0) || (st && o.wdata !== m_wdata(f, wd))) begin
          n_fail++; $display("FAIL rnd_req[%0d]: addr %h we %b wmask %b wdata %h unstable %b want addr %h wmask %b wdata %h",
                             i, o.addr, o.we, o.wmask, o.wdata, o.unstable, a - (a % 4),
                             st ? m_wmask(f, a) : 4'h0, m_wdata(f, wd));
        end
      end
      if ($urandom_range(0, 4) == 0) drive_idle(1);
    end
    drive_idle(1);
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store_same_cycle();
    test_misaligned();
    test_spurious_ack();
    test_reset_mid();
    test_long_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
